opb_register_simulink2ppc_snap: RTL
===================================

# opb_register_simulink2ppc_snap

OPB slave that carries a 32-bit value from user (Simulink) logic to the PowerPC, the reverse direction of the ppc2simulink control register. User logic presents a word with a valid strobe, and the block captures it into a holding register. The PPC reads the held value, a status word (new-data flag, overrun tracking) and a control word over OPB. Instantiated once per readback register in the XPS system wrappers; user logic runs on the same clock as the OPB.

## Interface
- C_BASEADDR, 32'h01004100, first byte address of the 256-byte slave window
- C_HIGHADDR, 32'h010041FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family string; no functional effect
- OPB_Clk  in  1  only clock; user ports are synchronous to it
- OPB_Rst_n  in  1  asynchronous, active-low reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  master transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; all zero whenever Sl_xferAck=0 (OR-bus)
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0
- user_data_in  in  [31:0]  word to publish
- user_valid  in  1  capture strobe, single cycle or held
- user_new  out  1  mirror of the status new-data flag

## Operation
- Bit order: OPB [0:31] maps DBus[0] to value bit 31.
- Register map, byte offsets from C_BASEADDR (ABus[24:29] decode):
  - 0x0 DATA (RO). Holds the captured word.
  - 0x4 STATUS (RO). Value = {ovf_cnt[15:0], 14'b0, overrun, new}.
  - 0x8 CTRL (RW). bit0 = freeze. bit1 = clear, self-clearing and always reads 0.
  - Other offsets read 0, ignore writes, and are acked.
- Capture: when user_valid=1 and freeze=0, DATA <= user_data_in and new <= 1.
  - If new was already 1 in that cycle, overrun <= 1 and ovf_cnt increments, saturating at 16'hFFFF.
  - When freeze=1, user_valid is ignored entirely (no capture, no overrun).
- A DATA read clears new. If a capture occurs in the same cycle as the clearing read, the capture wins: new stays 1 and no overrun is counted for that cycle.
- Writing CTRL with bit1=1 clears overrun and ovf_cnt. Clear beats a same-cycle overrun increment.
- CTRL writes honour byte enables; only BE[3] (bits 7:0) affects state.
- Slave FSM, states IDLE and ACK:
  - IDLE -> ACK when OPB_select=1 and the address is in the window.
  - ACK -> IDLE unconditionally.
  - ACK is never entered on two consecutive cycles. A select still high in the cycle after ACK is not re-acked.

## Timing
- Reset values: Sl_DBus=0, Sl_xferAck=0, DATA=0, new=0, overrun=0, ovf_cnt=0, freeze=0, user_new=0, FSM=IDLE.
- Reset asserted mid-transfer drops Sl_xferAck immediately (async) and returns the FSM to IDLE.
- Decode happens in cycle T, where select and address are valid. Sl_xferAck=1 and Sl_DBus valid in cycle T+1, for exactly one cycle.
- Read data is sampled from the register state at the end of cycle T.
- Side effects take effect at the T+1 clock edge: the DATA-read clear of new and CTRL writes.
- Capture latency is 1: user_valid at cycle C makes DATA visible to a read decoded at C+1, and user_new goes high at C+1.
- Held user_valid captures every cycle, so overrun counts every cycle after the first.

## Configuration
- OPB_S2P_OVERRUN_EN defined: overrun flag and 16-bit ovf_cnt are implemented as specified.
- Not defined: overrun and ovf_cnt logic are removed, and STATUS bits 31:1 read 0. The CTRL clear bit is accepted and has no effect. The new flag and capture behaviour are unchanged.

## Test plan
- Reset, then read 0x0 and 0x4 -> both return 0; Sl_xferAck high for exactly one cycle, 1 cycle after select.
- user_valid with 0xDEADBEEF, then read 0x4 -> 0x00000001; read 0x0 -> 0xDEADBEEF; read 0x4 again -> 0x00000000; user_new falls.
- Three user_valid pulses without reading (macro on) -> STATUS = 0x00020003; write CTRL=0x2 -> STATUS = 0x00000001.
- Write CTRL=0x1, then user_valid with 0x12345678 -> DATA unchanged, new unchanged; write CTRL=0x0, then capture -> DATA=0x12345678.
- user_valid in the same cycle as the DATA read's clearing edge -> new stays 1, ovf_cnt unchanged; Sl_DBus=0 on all non-ack cycles.
- Select held high for 4 cycles at an in-window address -> Sl_xferAck pulses at cycles 2 and 4 only; an out-of-window address is never acked.

Source files
------------

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave publishing a user-logic word to the PPC: DATA, STATUS and CTRL registers behind a one-cycle ack.
// Define OPB_S2P_OVERRUN_EN to build the overrun flag and saturating 16-bit overrun counter.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid,
    output logic        user_new
);

    localparam int unused_cfg = C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        new_q, new_d;
    logic        freeze_q, freeze_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
`ifdef OPB_S2P_OVERRUN_EN
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        hit_s;
    logic        start_s;
    logic [5:0]  offset_s;
    logic [7:0]  wbyte_s;
    logic        data_rd_s;
    logic        ctrl_wr_s;
    logic        capture_s;
    logic [31:0] status_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign unused_s  = ^{OPB_seqAddr, OPB_DBus[0:23], OPB_BE[0:2], OPB_ABus[30:31]};

    assign hit_s     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign start_s   = (state_q == ST_IDLE) && hit_s;
    assign offset_s  = OPB_ABus[24:29];
    assign wbyte_s   = OPB_DBus[24:31];
    assign data_rd_s = start_s && OPB_RNW && (offset_s == 6'd0);
    assign ctrl_wr_s = start_s && !OPB_RNW && (offset_s == 6'd2) && OPB_BE[3];
    assign capture_s = user_valid && !freeze_q;

`ifdef OPB_S2P_OVERRUN_EN
    assign status_s  = {cnt_q, 14'd0, ovr_q, new_q};
`else
    assign status_s  = {31'd0, new_q};
`endif

    // Read multiplexer over the register state as it stands in the decode cycle
    always_comb begin
        rd_mux_s = 32'd0;
        case (offset_s)
            6'd0:    rd_mux_s = data_q;
            6'd1:    rd_mux_s = status_s;
            6'd2:    rd_mux_s = {31'd0, freeze_q};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Slave FSM and register next-state; a capture beats a same-cycle clearing read
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        new_d    = new_q;
        freeze_d = freeze_q;
        rdata_d  = 32'd0;
        ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (OPB_RNW) begin
                        rdata_d = rd_mux_s;
                    end else begin
                        rdata_d = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (capture_s) begin
            data_d = user_data_in;
            new_d  = 1'b1;
        end else if (data_rd_s) begin
            new_d  = 1'b0;
        end else begin
            new_d  = new_q;
        end
        if (ctrl_wr_s) begin
            freeze_d = wbyte_s[0];
        end else begin
            freeze_d = freeze_q;
        end
    end

`ifdef OPB_S2P_OVERRUN_EN
    // Overrun tracking: clear wins over a same-cycle increment; counter saturates
    always_comb begin
        ovr_d = ovr_q;
        cnt_d = cnt_q;
        if (ctrl_wr_s && wbyte_s[1]) begin
            ovr_d = 1'b0;
            cnt_d = 16'd0;
        end else if (capture_s && new_q && !data_rd_s) begin
            ovr_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ovr_d = ovr_q;
            cnt_d = cnt_q;
        end
    end

    // Overrun state registers
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ovr_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            ovr_q <= ovr_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    // Main state registers
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= 32'd0;
            new_q    <= 1'b0;
            freeze_q <= 1'b0;
            rdata_q  <= 32'd0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            new_q    <= new_d;
            freeze_q <= freeze_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_new   = new_q;

endmodule
